axi4_to_wishbone_burst: RTL and testbench

AXI4_TO_WISHBONE_BURST -- requirements
Module: axi4_to_wishbone_burst

---
 rtl/axi4_to_wishbone_burst.sv | 297 +++++++++++++++++++++++++++++
 tb/tb_axi4_to_wishbone_burst.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_to_wishbone_burst.sv
// ---------------------------------------------------------------------------
// axi4_to_wishbone_burst
//
// Bridges an AXI4 slave port onto a classic Wishbone master.  One burst is in
// flight at a time; each AXI beat becomes one Wishbone cycle.  CYC/STB drop
// for at least one clock between beats, so a zero-wait slave costs two clocks
// per beat.
//
// Ports
//   clk, rst_n          : single clock, asynchronous active-low reset
//   S_AXI_AW* / W* / B* : AXI4 write address, write data, write response
//   S_AXI_AR* / R*      : AXI4 read address, read data
//   WB_*                : Wishbone master (CYC/STB/WE/ADDR/WDATA/SEL out,
//                         RDATA/ACK/ERR in)
//
// Optional feature
//   AXI2WB_TIMEOUT_EN   : when defined, a watchdog ends any Wishbone beat that
//                         has waited TIMEOUT_CYCLES clocks and reports it as
//                         SLVERR (read data forced to zero).  When undefined
//                         the bridge waits for ACK/ERR indefinitely.
// ---------------------------------------------------------------------------
module axi4_to_wishbone_burst #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int ID_WIDTH       = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  // AW channel
  input  logic [ID_WIDTH-1:0]       S_AXI_AWID,
  input  logic [ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [7:0]                S_AXI_AWLEN,
  input  logic [2:0]                S_AXI_AWSIZE,
  input  logic [1:0]                S_AXI_AWBURST,
  input  logic                      S_AXI_AWVALID,
  output logic                      S_AXI_AWREADY,
  // W channel
  input  logic [DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                      S_AXI_WLAST,
  input  logic                      S_AXI_WVALID,
  output logic                      S_AXI_WREADY,
  // B channel
  output logic [ID_WIDTH-1:0]       S_AXI_BID,
  output logic [1:0]                S_AXI_BRESP,
  output logic                      S_AXI_BVALID,
  input  logic                      S_AXI_BREADY,
  // AR channel
  input  logic [ID_WIDTH-1:0]       S_AXI_ARID,
  input  logic [ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [7:0]                S_AXI_ARLEN,
  input  logic [2:0]                S_AXI_ARSIZE,
  input  logic [1:0]                S_AXI_ARBURST,
  input  logic                      S_AXI_ARVALID,
  output logic                      S_AXI_ARREADY,
  // R channel
  output logic [ID_WIDTH-1:0]       S_AXI_RID,
  output logic [DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                S_AXI_RRESP,
  output logic                      S_AXI_RLAST,
  output logic                      S_AXI_RVALID,
  input  logic                      S_AXI_RREADY,
  // Wishbone master
  output logic                      WB_CYC,
  output logic                      WB_STB,
  output logic                      WB_WE,
  output logic [ADDR_WIDTH-1:0]     WB_ADDR,
  output logic [DATA_WIDTH-1:0]     WB_WDATA,
  output logic [DATA_WIDTH/8-1:0]   WB_SEL,
  input  logic [DATA_WIDTH-1:0]     WB_RDATA,
  input  logic                      WB_ACK,
  input  logic                      WB_ERR
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int MAX_SIZE   = $clog2(STRB_WIDTH);
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
    $error("axi4_to_wishbone_burst: DATA_WIDTH must be 32 or 64");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("axi4_to_wishbone_burst: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [2:0] {
    IDLE, W_DATA, W_BUS, W_RESP, R_BUS, R_DATA
  } state_t;

  state_t                  state_q, state_d;
  logic                    prefer_read_q;   // last grant was a write
  logic [ID_WIDTH-1:0]     id_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [7:0]              len_q;
  logic [7:0]              beat_q;
  logic [2:0]              size_q;
  logic [1:0]              burst_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [STRB_WIDTH-1:0]   strb_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    wr_err_q;        // sticky over the whole write burst
  logic                    rd_err_q;        // error of the current read beat

  logic                    grant_w, grant_r;
  logic                    timeout;
  logic                    bus_done, bus_err, last_beat;
  logic [2:0]              size_eff;
  logic [ADDR_WIDTH-1:0]   beat_addr;

  // WLAST carries no information here: the beat counter defines the end.
  logic unused_wlast;
  assign unused_wlast = S_AXI_WLAST;

  // Both requests pending: take the type not served last. prefer_read_q
  // resets low so the first contested grant goes to the write.
  assign grant_w = S_AXI_AWVALID && (!S_AXI_ARVALID || !prefer_read_q);
  assign grant_r = S_AXI_ARVALID && !grant_w;

  // ACK together with ERR counts as ERR; a watchdog expiry counts as ERR.
  assign bus_done  = WB_ACK || WB_ERR || timeout;
  assign bus_err   = WB_ERR || timeout;
  assign last_beat = (beat_q == len_q);

  // WRAP bursts are walked as INCR; oversized SIZE is clamped to bus width.
  always_comb begin
    size_eff  = (size_q > 3'(MAX_SIZE)) ? 3'(MAX_SIZE) : size_q;
    beat_addr = (burst_q == BURST_FIXED) ? addr_q
              : addr_q + (ADDR_WIDTH'(beat_q) << size_eff);
  end

`ifdef AXI2WB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q;
  logic            in_bus;

  assign in_bus = (state_q == W_BUS) || (state_q == R_BUS);

  // Counter sits at zero outside the bus states, so it is clear on entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      to_cnt_q <= '0;
    else if (in_bus) to_cnt_q <= to_cnt_q + TO_W'(1);
    else             to_cnt_q <= '0;
  end

  // Fires on the TIMEOUT_CYCLES-th clock with CYC high and no slave answer.
  assign timeout = in_bus && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1))
                   && !WB_ACK && !WB_ERR;
`else
  assign timeout = 1'b0;
`endif

  // ---------------------------------------------------------------- state
  // NOTE: clocked state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // ----------------------------------------------------------- next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant_w)           state_d = W_DATA;
               else if (grant_r)      state_d = R_BUS;
      W_DATA:  if (S_AXI_WVALID)      state_d = W_BUS;
      W_BUS:   if (bus_done)          state_d = last_beat ? W_RESP : W_DATA;
      W_RESP:  if (S_AXI_BREADY)      state_d = IDLE;
      R_BUS:   if (bus_done)          state_d = R_DATA;
      R_DATA:  if (S_AXI_RREADY)      state_d = last_beat ? IDLE : R_BUS;
      default:                        state_d = IDLE;
    endcase
  end

  // --------------------------------------------------------------- outputs
  // NOTE: every output gets a default before the case so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    S_AXI_AWREADY = 1'b0;
    S_AXI_ARREADY = 1'b0;
    S_AXI_WREADY  = 1'b0;
    S_AXI_BVALID  = 1'b0;
    S_AXI_RVALID  = 1'b0;
    S_AXI_RLAST   = 1'b0;
    WB_CYC        = 1'b0;
    WB_STB        = 1'b0;
    WB_WE         = 1'b0;
    WB_ADDR       = '0;
    WB_WDATA      = '0;
    WB_SEL        = '0;
    unique case (state_q)
      IDLE: begin
        // Grants are combinational from VALID; keep them low during reset.
        S_AXI_AWREADY = rst_n && grant_w;
        S_AXI_ARREADY = rst_n && grant_r;
      end
      W_DATA: S_AXI_WREADY = 1'b1;
      W_BUS: begin
        WB_CYC   = 1'b1;
        WB_STB   = 1'b1;
        WB_WE    = 1'b1;
        WB_ADDR  = beat_addr;
        WB_WDATA = wdata_q;
        WB_SEL   = strb_q;
      end
      W_RESP: S_AXI_BVALID = 1'b1;
      R_BUS: begin
        WB_CYC  = 1'b1;
        WB_STB  = 1'b1;
        WB_ADDR = beat_addr;
        WB_SEL  = '1;
      end
      R_DATA: begin
        S_AXI_RVALID = 1'b1;
        S_AXI_RLAST  = last_beat;
      end
      default: ;
    endcase
  end

  // Response fields come straight from registers that only change outside
  // the VALID window, so they are stable until accepted.
  assign S_AXI_BID   = id_q;
  assign S_AXI_BRESP = wr_err_q ? RESP_SLVERR : RESP_OKAY;
  assign S_AXI_RID   = id_q;
  assign S_AXI_RDATA = rdata_q;
  assign S_AXI_RRESP = rd_err_q ? RESP_SLVERR : RESP_OKAY;

  // -------------------------------------------------------------- datapath
  // NOTE: datapath registers are reset too, because reset must present zero
  // on RDATA, the IDs and the responses, not just an idle FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prefer_read_q <= 1'b0;
      id_q          <= '0;
      addr_q        <= '0;
      len_q         <= '0;
      beat_q        <= '0;
      size_q        <= '0;
      burst_q       <= '0;
      wdata_q       <= '0;
      strb_q        <= '0;
      rdata_q       <= '0;
      wr_err_q      <= 1'b0;
      rd_err_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (grant_w) begin
            prefer_read_q <= 1'b1;
            id_q          <= S_AXI_AWID;
            addr_q        <= S_AXI_AWADDR;
            len_q         <= S_AXI_AWLEN;
            size_q        <= S_AXI_AWSIZE;
            burst_q       <= S_AXI_AWBURST;
            beat_q        <= '0;
            wr_err_q      <= 1'b0;
          end else if (grant_r) begin
            prefer_read_q <= 1'b0;
            id_q          <= S_AXI_ARID;
            addr_q        <= S_AXI_ARADDR;
            len_q         <= S_AXI_ARLEN;
            size_q        <= S_AXI_ARSIZE;
            burst_q       <= S_AXI_ARBURST;
            beat_q        <= '0;
          end
        end
        W_DATA: begin
          if (S_AXI_WVALID) begin
            wdata_q <= S_AXI_WDATA;
            strb_q  <= S_AXI_WSTRB;
          end
        end
        W_BUS: begin
          if (bus_done) begin
            if (bus_err)    wr_err_q <= 1'b1;
            if (!last_beat) beat_q   <= beat_q + 8'd1;
          end
        end
        R_BUS: begin
          if (bus_done) begin
            rdata_q  <= timeout ? '0 : WB_RDATA;
            rd_err_q <= bus_err;
          end
        end
        R_DATA: begin
          if (S_AXI_RREADY && !last_beat) beat_q <= beat_q + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_to_wishbone_burst.sv
// ---------------------------------------------------------------------------
// tb_axi4_to_wishbone_burst
//
// Directed bench for axi4_to_wishbone_burst (32-bit data, TIMEOUT_CYCLES=16).
// A behavioural Wishbone slave answers combinationally; read data is the
// address XOR 32'hC0DE_0000.  Inputs change at posedge+1 only, and a negedge
// monitor logs Wishbone transfers, AXI grants and R handshakes.
// Watchdog scenario is compiled in only with AXI2WB_TIMEOUT_EN.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_axi4_to_wishbone_burst;

  localparam logic [31:0] RD_XOR = 32'hC0DE_0000;

  logic        clk, rst_n;
  logic [3:0]  awid, arid, bid, rid;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awvalid, awready, arvalid, arready;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic        bvalid, bready, rlast, rvalid, rready;
  logic        wb_cyc, wb_stb, wb_we, wb_ack, wb_err, err_now;
  logic [31:0] wb_addr, wb_wdata, wb_rdata;
  logic [3:0]  wb_sel;

  int checks = 0;
  int errors = 0;

  // slave controls
  logic ack_en;
  int   err_beat;
  int   w_sent;

  // monitor state
  logic [31:0] log_addr [64];
  logic [31:0] log_data [64];
  logic [3:0]  log_sel  [64];
  logic        log_we   [64];
  logic        grant_log [16];
  int wb_n = 0, g_n = 0, r_beats = 0, cyc_cycles = 0, gap_viol = 0;
  logic prev_done = 1'b0;

  axi4_to_wishbone_burst #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .S_AXI_AWID(awid), .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen),
    .S_AXI_AWSIZE(awsize), .S_AXI_AWBURST(awburst),
    .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast),
    .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BID(bid), .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid),
    .S_AXI_BREADY(bready),
    .S_AXI_ARID(arid), .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen),
    .S_AXI_ARSIZE(arsize), .S_AXI_ARBURST(arburst),
    .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RID(rid), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp),
    .S_AXI_RLAST(rlast), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .WB_CYC(wb_cyc), .WB_STB(wb_stb), .WB_WE(wb_we), .WB_ADDR(wb_addr),
    .WB_WDATA(wb_wdata), .WB_SEL(wb_sel), .WB_RDATA(wb_rdata),
    .WB_ACK(wb_ack), .WB_ERR(wb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Zero-wait slave; ERR replaces ACK on write beat err_beat (0-based).
  assign err_now  = wb_we && ((w_sent - 1) == err_beat);
  assign wb_ack   = wb_cyc && wb_stb && ack_en && !err_now;
  assign wb_err   = wb_cyc && wb_stb && ack_en && err_now;
  assign wb_rdata = wb_addr ^ RD_XOR;

  always @(negedge clk) begin
    if (wb_cyc && wb_stb && (wb_ack || wb_err)) begin
      if (wb_n < 64) begin
        log_addr[wb_n] = wb_addr;
        log_data[wb_n] = wb_wdata;
        log_sel[wb_n]  = wb_sel;
        log_we[wb_n]   = wb_we;
      end
      wb_n++;
    end
    if (prev_done && wb_cyc) gap_viol++;
    prev_done = wb_cyc && wb_stb && (wb_ack || wb_err);
    if (wb_cyc) cyc_cycles++;
    if (awvalid && awready) begin
      if (g_n < 16) grant_log[g_n] = 1'b0;
      g_n++;
    end
    if (arvalid && arready) begin
      if (g_n < 16) grant_log[g_n] = 1'b1;
      g_n++;
    end
    if (rvalid && rready) r_beats++;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end

  // ------------------------------------------------------------ helpers
  task automatic send_addr(input logic is_rd, input logic [3:0] id,
                           input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    if (is_rd) begin
      arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
      arvalid = 1'b1;
    end else begin
      awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst;
      awvalid = 1'b1;
    end
    @(negedge clk);
    while (!(is_rd ? arready : awready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!(is_rd ? arready : awready)) begin
      errors++;
      $display("FAIL addr_handshake(rd=%0b): ready got 0 required 1", is_rd);
    end
    @(posedge clk); #1;
    awvalid = 1'b0;
    arvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] data, input logic [3:0] strb,
                        input logic last);
    int n = 0;
    wdata = data; wstrb = strb; wlast = last; wvalid = 1'b1;
    @(negedge clk);
    while (!wready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!wready) begin
      errors++;
      $display("FAIL w_handshake: WREADY got 0 required 1");
    end
    @(posedge clk); #1;
    wvalid = 1'b0;
    w_sent++;
  endtask

  task automatic expect_b(input string name, input logic [3:0] id,
                          input logic [1:0] resp);
    int n = 0;
    @(negedge clk);
    while (!bvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!bvalid || bid !== id || bresp !== resp) begin
      errors++;
      $display("FAIL %s: bvalid=%b bid=%0h bresp=%0h required 1/%0h/%0h",
               name, bvalid, bid, bresp, id, resp);
    end
    @(posedge clk); #1 bready = 1'b1;
    @(posedge clk); #1 bready = 1'b0;
  endtask

  task automatic expect_r(input string name, input logic [31:0] data,
                          input logic [1:0] resp, input logic last,
                          input logic [3:0] id);
    int n = 0;
    @(negedge clk);
    while (!rvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!rvalid || rdata !== data || rresp !== resp || rlast !== last ||
        rid !== id) begin
      errors++;
      $display("FAIL %s: v=%b data=%h resp=%0h last=%b id=%0h required 1/%h/%0h/%b/%0h",
               name, rvalid, rdata, rresp, rlast, rid, data, resp, last, id);
    end
    @(posedge clk); #1 rready = 1'b1;
    @(posedge clk); #1 rready = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic check_log(input string name, input int idx,
                           input logic [31:0] addr, input logic we,
                           input logic [3:0] sel);
    checks++;
    if (idx >= 64 || log_addr[idx] !== addr || log_we[idx] !== we ||
        log_sel[idx] !== sel) begin
      errors++;
      $display("FAIL %s: wb[%0d] addr=%h we=%b sel=%h required %h/%b/%h",
               name, idx, log_addr[idx % 64], log_we[idx % 64],
               log_sel[idx % 64], addr, we, sel);
    end
  endtask

  task automatic check_count(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, got, want);
    end
  endtask

  // ------------------------------------------------------------ scenarios
  task automatic test_reset();
    awvalid = 1'b1; arvalid = 1'b1;
    #1;
    checks++;
    if ({awready, arready, wready, bvalid, rvalid, rlast,
         wb_cyc, wb_stb, wb_we} !== 9'b0) begin
      errors++;
      $display("FAIL reset_ctrl: %b required 000000000",
               {awready, arready, wready, bvalid, rvalid, rlast,
                wb_cyc, wb_stb, wb_we});
    end
    checks++;
    if ({rdata, wb_addr, wb_wdata, wb_sel, bid, rid, bresp, rresp} !== '0) begin
      errors++;
      $display("FAIL reset_data: rdata=%h wb_addr=%h wb_wdata=%h sel=%h required 0",
               rdata, wb_addr, wb_wdata, wb_sel);
    end
    awvalid = 1'b0; arvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_write();
    int base = wb_n;
    w_sent = 0; err_beat = -1;
    send_addr(1'b0, 4'h5, 32'h100, 8'd0, 3'd2, 2'b01);
    send_w(32'hDEAD_BEEF, 4'hF, 1'b1);
    expect_b("single_write_b", 4'h5, 2'b00);
    check_count("single_write_wb_count", wb_n - base, 1);
    check_log("single_write_wb", base, 32'h100, 1'b1, 4'hF);
    checks++;
    if (log_data[base % 64] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL single_write_data: got %h required deadbeef",
               log_data[base % 64]);
    end
  endtask

  task automatic test_incr_read();
    int base = wb_n;
    send_addr(1'b1, 4'h3, 32'h200, 8'd3, 3'd2, 2'b01);
    for (int i = 0; i < 4; i++)
      expect_r($sformatf("incr_read_r%0d", i), (32'h200 + 32'(4 * i)) ^ RD_XOR,
               2'b00, (i == 3), 4'h3);
    check_count("incr_read_wb_count", wb_n - base, 4);
    for (int i = 0; i < 4; i++)
      check_log($sformatf("incr_read_wb%0d", i), base + i,
                32'h200 + 32'(4 * i), 1'b0, 4'hF);
  endtask

  task automatic test_fixed_write_err();
    int base = wb_n;
    w_sent = 0; err_beat = 1;
    send_addr(1'b0, 4'hA, 32'h40, 8'd2, 3'd2, 2'b00);
    // WLAST held low throughout: only the beat counter ends the burst.
    for (int i = 0; i < 3; i++) send_w(32'h1111_0000 + 32'(i), 4'h3, 1'b0);
    expect_b("fixed_err_b", 4'hA, 2'b10);
    err_beat = -1;
    check_count("fixed_err_wb_count", wb_n - base, 3);
    for (int i = 0; i < 3; i++)
      check_log($sformatf("fixed_err_wb%0d", i), base + i, 32'h40, 1'b1, 4'h3);
  endtask

  task automatic test_arbitration();
    int gb, n;
    pulse_reset();
    gb = g_n; n = 0;
    awid = 4'h1; awaddr = 32'h600; awlen = 8'd0; awsize = 3'd2; awburst = 2'b01;
    arid = 4'h2; araddr = 32'h700; arlen = 8'd0; arsize = 3'd2; arburst = 2'b01;
    wdata = 32'h0BAD_F00D; wstrb = 4'hF; wlast = 1'b1;
    wvalid = 1'b1; bready = 1'b1; rready = 1'b1;
    awvalid = 1'b1; arvalid = 1'b1;
    while (g_n - gb < 4 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    awvalid = 1'b0; arvalid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    wvalid = 1'b0; bready = 1'b0; rready = 1'b0;
    check_count("arb_grants", (g_n - gb >= 4) ? 4 : g_n - gb, 4);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ((gb + i) >= 16 || grant_log[(gb + i) % 16] !== logic'(i % 2)) begin
        errors++;
        $display("FAIL arb_grant%0d: is_read=%b required %b",
                 i, grant_log[(gb + i) % 16], logic'(i % 2));
      end
    end
  endtask

  task automatic test_backpressure_reset();
    logic [31:0] held;
    int n = 0, rb, cb;
    send_addr(1'b1, 4'h7, 32'h300, 8'd3, 3'd2, 2'b01);
    @(negedge clk);
    while (!rvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    held = rdata;
    checks++;
    if (!rvalid || held !== (32'h300 ^ RD_XOR)) begin
      errors++;
      $display("FAIL bp_first_beat: v=%b data=%h required 1/%h",
               rvalid, held, 32'h300 ^ RD_XOR);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (!rvalid || rdata !== held) begin
        errors++;
        $display("FAIL bp_stall%0d: v=%b data=%h required 1/%h",
                 i, rvalid, rdata, held);
      end
    end
    // Second beat will find a silent slave so it is on the bus at reset.
    @(posedge clk); #1 ack_en = 1'b0; rready = 1'b1;
    @(posedge clk); #1 rready = 1'b0;
    @(negedge clk);
    checks++;
    if (wb_cyc !== 1'b1) begin
      errors++;
      $display("FAIL bp_beat2_on_bus: CYC got %b required 1", wb_cyc);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({wb_cyc, wb_stb, rvalid} !== 3'b000) begin
      errors++;
      $display("FAIL bp_reset_async: cyc/stb/rvalid=%b required 000",
               {wb_cyc, wb_stb, rvalid});
    end
    @(posedge clk); #1;
    rst_n = 1'b1; ack_en = 1'b1; rready = 1'b1;
    rb = r_beats; cb = cyc_cycles;
    repeat (20) @(posedge clk);
    #1 rready = 1'b0;
    check_count("bp_no_r_after_reset", r_beats - rb, 0);
    check_count("bp_no_cyc_after_reset", cyc_cycles - cb, 0);
  endtask

  task automatic test_size_clamp();
    int base = wb_n;
    send_addr(1'b1, 4'h9, 32'h500, 8'd1, 3'd3, 2'b01);
    expect_r("clamp_r0", 32'h500 ^ RD_XOR, 2'b00, 1'b0, 4'h9);
    expect_r("clamp_r1", 32'h504 ^ RD_XOR, 2'b00, 1'b1, 4'h9);
    check_log("clamp_wb0", base, 32'h500, 1'b0, 4'hF);
    check_log("clamp_wb1", base + 1, 32'h504, 1'b0, 4'hF);
  endtask

`ifdef AXI2WB_TIMEOUT_EN
  task automatic test_watchdog();
    int cb;
    ack_en = 1'b0;
    cb = cyc_cycles;
    send_addr(1'b1, 4'hC, 32'h400, 8'd0, 3'd2, 2'b01);
    expect_r("watchdog_r", 32'h0, 2'b10, 1'b1, 4'hC);
    check_count("watchdog_cyc_cycles", cyc_cycles - cb, 16);
    ack_en = 1'b1;
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
    bready = 1'b0; rready = 1'b0;
    ack_en = 1'b1; err_beat = -1; w_sent = 0;

    test_reset();
    test_single_write();
    test_incr_read();
    test_fixed_write_err();
    test_arbitration();
    test_backpressure_reset();
    test_size_clamp();
`ifdef AXI2WB_TIMEOUT_EN
    test_watchdog();
`endif
    check_count("cyc_gap_between_beats", gap_viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
